// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel valid/ready stream multiplexer with a registered
// output stage. Channel selection is either manual (sel) or round-robin
// among requesting channels. Also counts accepted input beats.
module rr_stream_mux #(
    parameter int WIDTH  = 4,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             xfer_cnt
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q,   out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [15:0]      xfer_cnt_q, xfer_cnt_d;
    logic [SEL_W-1:0] ptr_q,      ptr_d;

    logic             load;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic             xfer;
    logic [WIDTH-1:0] grant_data;

    // The output register may accept a new beat when empty or being drained.
    assign load = ~out_valid_q | out_ready;

    // Grant selection: manual looks only at the selected channel's valid;
    // round-robin takes the first valid channel at or after ptr, wrapping.
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        if (!mode) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SEL_W'(i);
                end
            end
        end else begin
            // Walk from the farthest candidate back to ptr so the closest
            // requesting channel is the one that sticks.
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                idx = int'(ptr_q) + k;
                if (idx >= NUM_CH) begin
                    idx = idx - NUM_CH;
                end
                if (in_valid[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SEL_W'(idx);
                end
            end
        end
    end

    // Ready is one-hot on the granted channel, and forced low during reset.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            in_ready[i] = rst_n & load & grant_valid & (grant_idx == SEL_W'(i));
        end
    end

    // Only the granted channel's data is routed, so other lanes never leak.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_valid && grant_idx == SEL_W'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer = |(in_ready & in_valid);

    // Next-state for output register, beat counter and round-robin pointer.
    always_comb begin
        int nxt;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        xfer_cnt_d  = xfer_cnt_q;
        ptr_d       = ptr_q;
        nxt         = int'(grant_idx) + 1;
        if (nxt >= NUM_CH) begin
            nxt = 0;
        end
        if (xfer) begin
            out_data_d  = grant_data;
            out_ch_d    = grant_idx;
            out_valid_d = 1'b1;
            xfer_cnt_d  = xfer_cnt_q + 16'd1;
            if (mode) begin
                ptr_d = SEL_W'(nxt);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            xfer_cnt_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            xfer_cnt_q  <= xfer_cnt_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Testbench for rr_stream_mux (WIDTH=4, NUM_CH=4): directed stimulus,
// a transaction-level reference model checked every cycle, and literal
// expectations at key points.
module tb_rr_stream_mux;

    localparam int N = 4;
    localparam int W = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic          mode;
    logic [1:0]    sel;
    logic [W-1:0]  out_data;
    logic [1:0]    out_ch;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   xfer_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    rr_stream_mux #(.WIDTH(W), .NUM_CH(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    logic       m_live = 1'b0;
    logic       m_valid;
    logic [3:0] m_data;
    int         m_ch;
    int         m_cnt;
    int         m_ptr;

    // Channel the rules pick this cycle, or -1 when nobody is granted.
    function automatic int m_grant();
        int c;
        if (!mode) begin
            if (int'(sel) < N && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        int g;
        g = m_grant();
        if (!rst_n || (m_valid && !out_ready) || g < 0) return '0;
        return N'(1) << g;
    endfunction

    always @(posedge clk) begin
        int g;
        logic [N-1:0] r;
        if (!rst_n) begin
            m_live  = 1'b1;
            m_valid = 1'b0;
            m_data  = '0;
            m_ch    = 0;
            m_cnt   = 0;
            m_ptr   = 0;
        end else if (m_live) begin
            g = m_grant();
            r = m_ready();
            if (g >= 0 && r[g] && in_valid[g]) begin
                m_data  = in_data[g*W +: W];
                m_ch    = g;
                m_valid = 1'b1;
                m_cnt   = (m_cnt + 1) % 65536;
                if (mode) m_ptr = (g + 1) % N;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model out_valid", 32'(out_valid), 32'(m_valid));
            chk("model out_data",  32'(out_data),  32'(m_data));
            chk("model out_ch",    32'(out_ch),    32'(m_ch));
            chk("model xfer_cnt",  32'(xfer_cnt),  32'(m_cnt));
            chk("model in_ready",  32'(in_ready),  32'(m_ready()));
        end
    end

    // ---------------- directed stimulus ----------------
    int rr_exp[5]   = '{0, 1, 2, 3, 0};
    int skip_exp[4] = '{1, 3, 1, 3};

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'hF;
        in_data   = 16'h4321;
        mode      = 1'b0;
        sel       = 2'd0;
        out_ready = 1'b1;

        // Reset held two cycles with every channel requesting
        tick();
        tick();
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data",  32'(out_data),  32'd0);
        chk("reset in_ready",  32'(in_ready),  32'd0);
        chk("reset xfer_cnt",  32'(xfer_cnt),  32'd0);

        // Manual select of channel 2
        rst_n    = 1'b1;
        in_data  = 16'h4A21;
        in_valid = 4'b0100;
        sel      = 2'd2;
        #1;
        chk("manual in_ready", 32'(in_ready), 32'b0100);
        tick();
        chk("manual out_data",  32'(out_data),  32'hA);
        chk("manual out_ch",    32'(out_ch),    32'd2);
        chk("manual out_valid", 32'(out_valid), 32'd1);
        sel = 2'd1;
        #1;
        chk("manual idle in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("manual drain out_valid", 32'(out_valid), 32'd0);

        // Round-robin rotation from a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        mode     = 1'b1;
        in_valid = 4'hF;
        in_data  = 16'h4321;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr out_ch",   32'(out_ch),   32'(rr_exp[i]));
            chk("rr out_data", 32'(out_data), 32'(rr_exp[i] + 1));
        end
        chk("rr xfer_cnt", 32'(xfer_cnt), 32'd5);

        // Round-robin skipping idle channels
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("skip out_ch", 32'(out_ch), 32'(skip_exp[i]));
        end
        chk("skip xfer_cnt", 32'(xfer_cnt), 32'd9);

        // Backpressure holding 0x7
        mode     = 1'b0;
        sel      = 2'd0;
        in_data  = 16'h4327;
        in_valid = 4'b0001;
        tick();
        chk("bp load out_data", 32'(out_data), 32'h7);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp in_ready", 32'(in_ready), 32'd0);
            tick();
            chk("bp out_data",  32'(out_data),  32'h7);
            chk("bp out_valid", 32'(out_valid), 32'd1);
            chk("bp xfer_cnt",  32'(xfer_cnt),  32'd10);
        end
        in_data   = 16'h4329;
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 32'(in_ready), 32'b0001);
        tick();
        chk("bp release out_data",  32'(out_data),  32'h9);
        chk("bp release out_valid", 32'(out_valid), 32'd1);
        chk("bp release xfer_cnt",  32'(xfer_cnt),  32'd11);

        // Advance the pointer, then reset with a beat pending
        mode     = 1'b1;
        in_valid = 4'hF;
        in_data  = 16'h4321;
        tick();
        chk("pre-reset out_ch", 32'(out_ch), 32'd0);
        rst_n = 1'b0;
        tick();
        chk("midreset out_valid", 32'(out_valid), 32'd0);
        chk("midreset out_data",  32'(out_data),  32'd0);
        chk("midreset xfer_cnt",  32'(xfer_cnt),  32'd0);
        rst_n = 1'b1;
        #1;
        chk("midreset ptr restart", 32'(in_ready), 32'b0001);

        // Counter wrap
        repeat (65535) tick();
        chk("wrap xfer_cnt ffff", 32'(xfer_cnt), 32'hFFFF);
        tick();
        chk("wrap xfer_cnt 0", 32'(xfer_cnt), 32'h0);
        chk("wrap out_ch",     32'(out_ch),   32'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
